// File: rtl/vga_map_pkg.sv
// Shared constants and types for the VGA text-map writer: geometry defaults,
// APB address regions, control register word offsets and FSM states.
package vga_map_pkg;

    localparam int COLS_DEF  = 80;
    localparam int ROWS_DEF  = 30;
    localparam int CELLS_DEF = COLS_DEF * ROWS_DEF;

    // Address bits [15:14] select which map or register block is accessed.
    typedef enum logic [1:0] {
        REGION_CHAR = 2'b00,
        REGION_COL  = 2'b01,
        REGION_CTRL = 2'b10,
        REGION_RSVD = 2'b11
    } region_e;

    // Control register word offsets, taken from address bits [13:2].
    localparam logic [11:0] OFF_FILL_DATA = 12'h000;
    localparam logic [11:0] OFF_FILL_CTRL = 12'h001;
    localparam logic [11:0] OFF_STATUS    = 12'h002;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        FILL
    } state_e;

endpackage

// File: rtl/vga_map_writer_if.sv
// APB slave bus bundle for the map writer. Signal names keep the slave-side
// _i/_o suffixes so the design and the bench read the same way.
interface vga_map_writer_if;

    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [15:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

endinterface

// File: rtl/vga_fill_counter.sv
// Cell index counter for the fill engine: start loads 0, enable steps by one,
// last flags the final cell so the engine can stop without overrunning.
module vga_fill_counter #(
    parameter int CELLS = vga_map_pkg::CELLS_DEF,
    parameter int IDXW  = $clog2(CELLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            en_i,
    output logic [IDXW-1:0] cnt_o,
    output logic            last_o
);

    logic [IDXW-1:0] cnt_q, cnt_d;

    // Next count: start takes priority over stepping.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + IDXW'(1);
        end
    end

    // Count register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == IDXW'(CELLS - 1));

endmodule

// File: rtl/vga_map_writer.sv
// APB slave that writes the character and colour maps of a VGA text display,
// reads the colour map back through its synchronous port, and runs a fill
// engine that paints every cell with one char/colour pair.
module vga_map_writer
    import vga_map_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int CELLS = COLS * ROWS,
    parameter int IDXW  = $clog2(CELLS)
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_map_writer_if.slave          apb,
    output logic [IDXW-1:0]          ch_map_addr_o,
    output logic [7:0]               ch_map_data_o,
    output logic                     ch_map_wen_o,
    output logic [IDXW-1:0]          col_map_addr_o,
    output logic [7:0]               col_map_data_o,
    output logic                     col_map_wen_o,
    input  logic [7:0]               col_map_rdata_i,
    output logic                     busy_o
);

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic [15:0]     fill_data_q, fill_data_d;
    logic [IDXW-1:0] ch_addr_q, ch_addr_d;
    logic [7:0]      ch_data_q, ch_data_d;
    logic            ch_wen_q, ch_wen_d;
    logic [IDXW-1:0] col_addr_q, col_addr_d;
    logic [7:0]      col_data_q, col_data_d;
    logic            col_wen_q, col_wen_d;

    logic            cnt_start, cnt_en, cnt_last;
    logic [IDXW-1:0] cnt;

    logic            access;
    region_e         region;
    logic [11:0]     word;
    logic            idx_ok;
    logic [31:0]     prdata;
    logic            pready, pslverr;
    logic            unused_bits;

    assign access = apb.psel_i & apb.penable_i;
    assign region = region_e'(apb.paddr_i[15:14]);
    assign word   = apb.paddr_i[13:2];
    assign idx_ok = (32'(word) < 32'(CELLS));
    // Byte lanes below the word and upper write data carry no meaning here.
    assign unused_bits = ^{apb.paddr_i[1:0], apb.pwdata_i[31:16]};

    vga_fill_counter #(
        .CELLS (CELLS),
        .IDXW  (IDXW)
    ) u_fill_counter (
        .clk     (clk),
        .rst     (rst),
        .start_i (cnt_start),
        .en_i    (cnt_en),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    // Next state, bus response and next values of the registered map ports.
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        fill_data_d = fill_data_q;
        ch_wen_d    = 1'b0;
        ch_addr_d   = ch_addr_q;
        ch_data_d   = ch_data_q;
        col_wen_d   = 1'b0;
        col_addr_d  = col_addr_q;
        col_data_d  = col_data_q;
        cnt_start   = 1'b0;
        cnt_en      = 1'b0;
        pready      = 1'b0;
        pslverr     = 1'b0;
        prdata      = '0;

        // Control registers answer with zero wait whether idle or filling.
        if (access && region == REGION_CTRL && (state_q == IDLE || state_q == FILL)) begin
            pready = 1'b1;
            case (word)
                OFF_FILL_DATA: begin
                    if (apb.pwrite_i) fill_data_d = apb.pwdata_i[15:0];
                    else              prdata      = {16'd0, fill_data_q};
                end
                OFF_FILL_CTRL: ;
                OFF_STATUS: begin
                    if (!apb.pwrite_i) prdata = {31'd0, busy_q};
                end
                default: pslverr = 1'b1;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (region == REGION_CTRL) begin
                        // The fill is only armed from idle; data is captured into
                        // the output registers here and held for the whole fill.
                        if (word == OFF_FILL_CTRL && apb.pwrite_i && apb.pwdata_i[0]) begin
                            state_d    = FILL;
                            busy_d     = 1'b1;
                            cnt_start  = 1'b1;
                            ch_wen_d   = 1'b1;
                            col_wen_d  = 1'b1;
                            ch_addr_d  = '0;
                            col_addr_d = '0;
                            ch_data_d  = fill_data_q[7:0];
                            col_data_d = fill_data_q[15:8];
                        end
                    end else if (region == REGION_RSVD || !idx_ok) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else if (region == REGION_CHAR) begin
                        // Char map is write-only; reads complete with zero data.
                        pready = 1'b1;
                        if (apb.pwrite_i) begin
                            ch_wen_d  = 1'b1;
                            ch_addr_d = IDXW'(word);
                            ch_data_d = apb.pwdata_i[7:0];
                        end
                    end else if (apb.pwrite_i) begin
                        pready     = 1'b1;
                        col_wen_d  = 1'b1;
                        col_addr_d = IDXW'(word);
                        col_data_d = apb.pwdata_i[7:0];
                    end else begin
                        // Colour read: present the address, wait out the RAM latency.
                        col_addr_d = IDXW'(word);
                        state_d    = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                pready  = access;
                if (access) prdata = {24'd0, col_map_rdata_i};
                state_d = IDLE;
            end
            FILL: begin
                // Map accesses stall (pready stays low) until the fill finishes.
                if (cnt_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_en     = 1'b1;
                    ch_wen_d   = 1'b1;
                    col_wen_d  = 1'b1;
                    ch_addr_d  = cnt + IDXW'(1);
                    col_addr_d = cnt + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered map-port outputs; reset aborts any fill or read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            fill_data_q <= '0;
            ch_wen_q    <= 1'b0;
            ch_addr_q   <= '0;
            ch_data_q   <= '0;
            col_wen_q   <= 1'b0;
            col_addr_q  <= '0;
            col_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            fill_data_q <= fill_data_d;
            ch_wen_q    <= ch_wen_d;
            ch_addr_q   <= ch_addr_d;
            ch_data_q   <= ch_data_d;
            col_wen_q   <= col_wen_d;
            col_addr_q  <= col_addr_d;
            col_data_q  <= col_data_d;
        end
    end

    assign apb.prdata_o  = prdata;
    assign apb.pready_o  = pready;
    assign apb.pslverr_o = pslverr;

    assign ch_map_addr_o  = ch_addr_q;
    assign ch_map_data_o  = ch_data_q;
    assign ch_map_wen_o   = ch_wen_q;
    assign col_map_addr_o = col_addr_q;
    assign col_map_data_o = col_data_q;
    assign col_map_wen_o  = col_wen_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_vga_map_writer.sv
// Directed bench for vga_map_writer: APB master tasks, a behavioural colour
// BRAM, and hand-computed expectations for writes, reads, errors and fills.
module tb_vga_map_writer;

    localparam int CELLS = 2400;
    localparam int IDXW  = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IDXW-1:0] ch_map_addr, col_map_addr;
    logic [7:0]      ch_map_data, col_map_data, col_map_rdata;
    logic            ch_map_wen, col_map_wen, busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [7:0] col_mem [0:4095];

    vga_map_writer_if bus ();

    vga_map_writer dut (
        .clk             (clk),
        .rst             (rst),
        .apb             (bus.slave),
        .ch_map_addr_o   (ch_map_addr),
        .ch_map_data_o   (ch_map_data),
        .ch_map_wen_o    (ch_map_wen),
        .col_map_addr_o  (col_map_addr),
        .col_map_data_o  (col_map_data),
        .col_map_wen_o   (col_map_wen),
        .col_map_rdata_i (col_map_rdata),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous colour RAM: read-first, data one cycle after the address.
    always @(posedge clk) begin
        if (col_map_wen) col_mem[col_map_addr] <= col_map_data;
        col_map_rdata <= col_mem[col_map_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_access(input logic [15:0] addr, input logic wr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
    endtask

    task automatic end_access();
        @(posedge clk); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
    endtask

    task automatic wait_ready(input int max_cyc, output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.pready_o && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        int fill_err, waited, t0, n, stray;
        for (int i = 0; i < 4096; i++) col_mem[i] = 8'h00;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0;  bus.pwdata_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ch_wen",   ch_map_wen,   0);
        check("rst_col_wen",  col_map_wen,  0);
        check("rst_busy",     busy,         0);
        check("rst_ch_addr",  ch_map_addr,  0);
        check("rst_col_data", col_map_data, 0);
        check("rst_pready",   bus.pready_o, 0);
        check("rst_pslverr",  bus.pslverr_o, 0);
        rst = 1'b0;

        start_access(16'h8000, 1'b0, 0);
        @(negedge clk);
        check("fdata_rst_rd", bus.prdata_o, 0);
        end_access();

        // Char write: zero-wait, one-cycle strobe next cycle
        start_access(16'h0010, 1'b1, 32'h41);
        @(negedge clk);
        check("chw_pready", bus.pready_o, 1);
        check("chw_no_early_wen", ch_map_wen, 0);
        end_access();
        @(negedge clk);
        check("chw_wen",  ch_map_wen,  1);
        check("chw_addr", ch_map_addr, 4);
        check("chw_data", ch_map_data, 8'h41);
        check("chw_col_quiet", col_map_wen, 0);
        check("idle_pready", bus.pready_o, 0);
        @(negedge clk);
        check("chw_one_cycle", ch_map_wen, 0);

        // Last valid cell
        start_access(16'h257C, 1'b1, 32'h5B);
        @(negedge clk);
        check("last_pslverr", bus.pslverr_o, 0);
        end_access();
        @(negedge clk);
        check("last_addr", {ch_map_wen, ch_map_addr}, {1'b1, 12'd2399});

        // Char map read returns zero
        start_access(16'h0010, 1'b0, 0);
        @(negedge clk);
        check("chr_rd", {bus.pready_o, bus.pslverr_o, bus.prdata_o}, {2'b10, 32'h0});
        end_access();

        // Colour write then read back through the RAM
        start_access(16'h4020, 1'b1, 32'h1F);
        @(negedge clk);
        check("colw_pready", bus.pready_o, 1);
        end_access();
        @(negedge clk);
        check("colw_port", {col_map_wen, col_map_addr, col_map_data}, {1'b1, 12'd8, 8'h1F});
        start_access(16'h4020, 1'b0, 0);
        @(negedge clk);
        check("colr_wait1", bus.pready_o, 0);
        @(negedge clk);
        check("colr_wait2", bus.pready_o, 0);
        @(negedge clk);
        check("colr_ready", bus.pready_o, 1);
        check("colr_data",  bus.prdata_o, 32'h1F);
        end_access();
        @(negedge clk);
        check("colr_prdata_clr", bus.prdata_o, 0);

        // Error responses
        start_access(16'h2580, 1'b1, 32'h55);
        @(negedge clk);
        check("oob_err", {bus.pready_o, bus.pslverr_o, bus.prdata_o}, {2'b11, 32'h0});
        end_access();
        @(negedge clk);
        check("oob_no_wen", {ch_map_wen, col_map_wen}, 2'b00);
        start_access(16'h6580, 1'b0, 0);
        @(negedge clk);
        check("oob_col_rd", {bus.pready_o, bus.pslverr_o}, 2'b11);
        end_access();
        start_access(16'hC000, 1'b0, 0);
        @(negedge clk);
        check("rsvd_err", {bus.pready_o, bus.pslverr_o, bus.prdata_o}, {2'b11, 32'h0});
        end_access();
        start_access(16'h800C, 1'b0, 0);
        @(negedge clk);
        check("ctrl_bad_off", {bus.pready_o, bus.pslverr_o}, 2'b11);
        end_access();

        // Fill with 0x0720; status and FILL_DATA accessed mid-fill
        start_access(16'h8000, 1'b1, 32'h0720);
        @(negedge clk);
        check("fdata_wr", bus.pready_o, 1);
        end_access();
        start_access(16'h8000, 1'b0, 0);
        @(negedge clk);
        check("fdata_rd", bus.prdata_o, 32'h0720);
        end_access();
        start_access(16'h8004, 1'b1, 32'h1);
        @(negedge clk);
        check("fctrl_wr", {bus.pready_o, busy}, 2'b10);
        end_access();
        fill_err = 0;
        fork
            begin
                for (int k = 0; k < CELLS; k++) begin
                    @(negedge clk);
                    if (!(ch_map_wen && col_map_wen && busy && ch_map_addr == k &&
                          col_map_addr == k && ch_map_data == 8'h20 && col_map_data == 8'h07))
                        fill_err++;
                end
                @(negedge clk);
                check("fill1_writes", fill_err, 0);
                check("fill1_done", {busy, ch_map_wen, col_map_wen}, 3'b000);
            end
            begin
                repeat (50) @(posedge clk);
                start_access(16'h8008, 1'b0, 0);
                @(negedge clk);
                check("status_mid", {bus.pready_o, bus.prdata_o}, {1'b1, 32'h1});
                end_access();
                start_access(16'h8000, 1'b1, 32'h1234);
                @(negedge clk);
                check("fdata_mid_wr", bus.pready_o, 1);
                end_access();
                start_access(16'h8004, 1'b1, 32'h1);
                @(negedge clk);
                check("fctrl_mid_ign", bus.pready_o, 1);
                end_access();
            end
        join
        start_access(16'h8008, 1'b0, 0);
        @(negedge clk);
        check("status_after", bus.prdata_o, 0);
        end_access();

        // Second fill uses 0x1234; a char write issued mid-fill stalls until IDLE
        start_access(16'h8004, 1'b1, 32'h1);
        @(negedge clk);
        t0 = cyc;
        end_access();
        @(negedge clk);
        check("fill2_first", {ch_map_addr, ch_map_data, col_map_data}, {12'd0, 8'h34, 8'h12});
        repeat (10) @(posedge clk);
        start_access(16'h0020, 1'b1, 32'h5A);
        wait_ready(3000, waited);
        check("stall_ready", bus.pready_o, 1);
        check("stall_len", cyc - t0, CELLS + 1);
        check("stall_busy", busy, 0);
        end_access();
        @(negedge clk);
        check("stall_write", {ch_map_wen, ch_map_addr, ch_map_data}, {1'b1, 12'd8, 8'h5A});

        // Reset at fill index 100
        start_access(16'h8004, 1'b1, 32'h1);
        end_access();
        n = 0;
        @(negedge clk);
        while (ch_map_addr != 100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rst_fill_reach100", {ch_map_wen, ch_map_addr}, {1'b1, 12'd100});
        rst = 1'b1;
        @(negedge clk);
        check("rst_fill_stop", {busy, ch_map_wen, col_map_wen}, 3'b000);
        rst = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (ch_map_wen || col_map_wen || busy) stray++;
        end
        check("rst_fill_quiet", stray, 0);
        start_access(16'h8000, 1'b0, 0);
        @(negedge clk);
        check("rst_fdata_clr", bus.prdata_o, 0);
        end_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
